// File: rtl/uart_pkg.sv
`timescale 1ns/1ps
// uart_pkg
// Shared definitions for the UART transmit framer and its receive-side
// counterpart.
//   state_t              framer state encoding
//   PAR_NONE/EVEN/ODD    parity mode encoding for the PARITY parameter
//   DEFAULT_CLKS_PER_BIT default bit period in clk cycles, common to tx and rx
//   parity_bit()         line value of the parity bit for a data word
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   localparam int DEFAULT_CLKS_PER_BIT = 10;

   // The word is zero-extended to the widest legal frame (9 bits).
   // Extra zero bits do not change the XOR.
   function automatic logic parity_bit(input logic [8:0] word, input int mode);
      return (^word) ^ (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_framer_if.sv
`timescale 1ns/1ps
// uart_tx_framer_if
// Producer-to-framer handshake plus the serial line.
//   datatx  word to send (producer -> framer)
//   start   send request (producer -> framer)
//   ready   framer idle, able to accept (framer -> producer)
//   tx      serial line, idles high (framer -> link)
//   done    one-cycle end-of-frame pulse (framer -> producer)
// Modports: master = producer side, slave = framer side.
interface uart_tx_framer_if #(
   parameter int DATA_WIDTH = 8
);
   logic [DATA_WIDTH-1:0] datatx;
   logic                  start;
   logic                  ready;
   logic                  tx;
   logic                  done;

   modport master (output datatx, output start, input ready, input tx, input done);
   modport slave  (input datatx, input start, output ready, output tx, output done);
endinterface

// File: rtl/uart_bit_timer.sv
`timescale 1ns/1ps
// uart_bit_timer
// Bit-period counter. It counts 0..CLKS_PER_BIT-1 while enabled and wraps
// back to 0. bit_end is high during the last cycle of each period.
//   clk      system clock
//   reset    asynchronous active-high reset
//   clear    synchronous restart of the period (takes priority over enable)
//   enable   count while high; hold while low
//   bit_end  high during count CLKS_PER_BIT-1 (one cycle per period)
module uart_bit_timer
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic bit_end
);
   localparam int              CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt_reg;
   logic [CW-1:0] cnt_next;

   always_comb begin
      cnt_next = cnt_reg;
      if (clear) begin
         cnt_next = '0;
      end else if (enable) begin
         cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   assign bit_end = enable && !clear && (cnt_reg == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
`timescale 1ns/1ps
// uart_tx_framer
// Serialises one word per start/ready handshake onto tx. The frame is a
// start bit, the data bits LSB first, an optional parity bit, and then the
// stop bit(s). Every bit lasts CLKS_PER_BIT clk cycles.
//   clk    system clock, rising edge
//   reset  asynchronous active-high reset; aborts any frame in flight
//   bus    uart_tx_framer_if.slave: datatx/start in, ready/tx/done out
module uart_tx_framer
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH   = 8,
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int PARITY       = PAR_NONE,
   parameter int STOP_BITS    = 1
) (
   input  logic               clk,
   input  logic               reset,
   uart_tx_framer_if.slave    bus
);
   generate
      if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 ||
          !(STOP_BITS == 1 || STOP_BITS == 2) ||
          DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_params
         $fatal(1, "uart_tx_framer: illegal parameter combination");
      end
   endgenerate

   localparam int            BW        = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

   state_t                  state_reg,   state_next;
   logic [DATA_WIDTH-1:0]   shift_reg,   shift_next;
   logic [BW-1:0]           bit_cnt_reg, bit_cnt_next;
   logic                    par_reg,     par_next;
   logic                    tx_reg,      tx_next;
   logic                    ready_reg,   ready_next;
   logic                    done_reg,    done_next;

   logic accept;
   logic bit_end;

   assign accept = bus.start && ready_reg;

   // The timer restarts on accept, so the start bit spans exactly one period
   // from the accept edge.
   uart_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (accept),
      .enable  (state_reg != ST_IDLE),
      .bit_end (bit_end)
   );

   always_comb begin
      state_next   = state_reg;
      shift_next   = shift_reg;
      bit_cnt_next = bit_cnt_reg;
      par_next     = par_reg;
      tx_next      = tx_reg;
      ready_next   = ready_reg;
      done_next    = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (accept) begin
               shift_next   = bus.datatx;
               par_next     = parity_bit(9'(bus.datatx), PARITY);
               bit_cnt_next = '0;
               tx_next      = 1'b0;
               ready_next   = 1'b0;
               state_next   = ST_START;
            end
         end
         ST_START: begin
            if (bit_end) begin
               tx_next    = shift_reg[0];
               shift_next = shift_reg >> 1;
               state_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               if (bit_cnt_reg == LAST_DATA) begin
                  // The bit counter is reused to count the stop bits.
                  bit_cnt_next = '0;
                  if (PARITY != PAR_NONE) begin
                     tx_next    = par_reg;
                     state_next = ST_PARITY;
                  end else begin
                     tx_next    = 1'b1;
                     state_next = ST_STOP;
                  end
               end else begin
                  tx_next      = shift_reg[0];
                  shift_next   = shift_reg >> 1;
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         ST_PARITY: begin
            if (bit_end) begin
               tx_next    = 1'b1;
               state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (bit_end) begin
               if (bit_cnt_reg == LAST_STOP) begin
                  ready_next = 1'b1;
                  done_next  = 1'b1;
                  state_next = ST_IDLE;
               end else begin
                  bit_cnt_next = bit_cnt_reg + 1'b1;
               end
            end
         end
         default: begin
            tx_next    = 1'b1;
            ready_next = 1'b1;
            state_next = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg   <= ST_IDLE;
         shift_reg   <= '0;
         bit_cnt_reg <= '0;
         par_reg     <= 1'b0;
         tx_reg      <= 1'b1;
         ready_reg   <= 1'b1;
         done_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         shift_reg   <= shift_next;
         bit_cnt_reg <= bit_cnt_next;
         par_reg     <= par_next;
         tx_reg      <= tx_next;
         ready_reg   <= ready_next;
         done_reg    <= done_next;
      end
   end

   assign bus.tx    = tx_reg;
   assign bus.ready = ready_reg;
   assign bus.done  = done_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
`timescale 1ns/1ps
// tb_uart_tx_framer
// Directed bench. It has three framers: no parity, even parity and odd
// parity. Expected line patterns are hand-computed frame vectors. Bit 0 of
// each vector is the start bit.
module tb_uart_tx_framer;
   import uart_pkg::*;

   localparam int CPB = 10;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   uart_tx_framer_if #(.DATA_WIDTH(8)) if0 ();
   uart_tx_framer_if #(.DATA_WIDTH(8)) if1 ();
   uart_tx_framer_if #(.DATA_WIDTH(8)) if2 ();

   uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_NONE), .STOP_BITS(1))
      dut0 (.clk(clk), .reset(reset), .bus(if0));
   uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_EVEN), .STOP_BITS(1))
      dut1 (.clk(clk), .reset(reset), .bus(if1));
   uart_tx_framer #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(PAR_ODD), .STOP_BITS(1))
      dut2 (.clk(clk), .reset(reset), .bus(if2));

   function automatic logic get_tx(input int w);
      case (w)
         0:       return if0.tx;
         1:       return if1.tx;
         default: return if2.tx;
      endcase
   endfunction

   function automatic logic get_ready(input int w);
      case (w)
         0:       return if0.ready;
         1:       return if1.ready;
         default: return if2.ready;
      endcase
   endfunction

   function automatic logic get_done(input int w);
      case (w)
         0:       return if0.done;
         1:       return if1.done;
         default: return if2.done;
      endcase
   endfunction

   task automatic set_in(input int w, input logic [7:0] d, input logic s);
      case (w)
         0:       begin if0.datatx = d; if0.start = s; end
         1:       begin if1.datatx = d; if1.start = s; end
         default: begin if2.datatx = d; if2.start = s; end
      endcase
   endtask

   task automatic set_start(input int w, input logic s);
      case (w)
         0:       if0.start = s;
         1:       if1.start = s;
         default: if2.start = s;
      endcase
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at the first falling edge after the accept edge (sample k=0).
   // Every bit period is checked to hold the expected level for all CPB
   // samples. After the frame, tail extra samples are watched for ready and
   // done.
   task automatic frame_check(input int w, input string tag, input logic [10:0] exp,
                              input int nbits, input int tail, input bit hold,
                              input bit pulses);
      int             ready_low = 0;
      int             done_cnt  = 0;
      int             done_k    = -1;
      int             last;
      logic [CPB-1:0] pv;
      last = nbits * CPB + tail;
      pv   = '0;
      if (!hold) set_start(w, 1'b0);
      for (int k = 0; k < last; k++) begin
         if (k < nbits * CPB) begin
            pv[k % CPB] = get_tx(w);
            if (k % CPB == CPB - 1)
               chk($sformatf("%s period%0d", tag, k / CPB), 32'(pv),
                   32'({CPB{exp[k / CPB]}}));
         end
         if (k == nbits * CPB)
            chk($sformatf("%s idle_after_stop", tag), 32'(get_tx(w)), 32'd1);
         if (!get_ready(w)) ready_low++;
         if (get_done(w)) begin
            done_cnt++;
            if (done_k < 0) done_k = k;
         end
         if (pulses && (k == 3 * CPB - 1 || k == 6 * CPB - 1)) set_start(w, 1'b1);
         else if (pulses && (k == 3 * CPB || k == 6 * CPB)) set_start(w, 1'b0);
         @(negedge clk);
      end
      chk($sformatf("%s ready_low_cycles", tag), 32'(ready_low), 32'(nbits * CPB));
      chk($sformatf("%s done_count", tag), 32'(done_cnt), 32'd1);
      chk($sformatf("%s done_cycle", tag), 32'(done_k), 32'(nbits * CPB));
   endtask

   initial begin
      int bad;
      int done_cnt;
      set_in(0, 8'h00, 1'b0);
      set_in(1, 8'h00, 1'b0);
      set_in(2, 8'h00, 1'b0);

      // Reset held 53 ns.
      #20;
      chk("rst tx", 32'(if0.tx), 32'd1);
      chk("rst ready", 32'(if0.ready), 32'd1);
      chk("rst done", 32'(if0.done), 32'd0);
      #33 reset = 1'b0;
      @(negedge clk);

      // Idle for 200 cycles with start low.
      bad = 0;
      for (int i = 0; i < 200; i++) begin
         for (int w = 0; w < 3; w++)
            if (get_tx(w) !== 1'b1 || get_ready(w) !== 1'b1 || get_done(w) !== 1'b0) bad++;
         @(negedge clk);
      end
      chk("idle 200 cycles deviations", 32'(bad), 32'd0);

      // 8'hED, no parity: 0,1,0,1,1,0,1,1,1,1.
      set_in(0, 8'hED, 1'b1);
      @(negedge clk);
      frame_check(0, "ed_none", 11'h3DA, 10, 20, 1'b0, 1'b0);

      // 8'hED, even parity -> parity bit 0.
      set_in(1, 8'hED, 1'b1);
      @(negedge clk);
      frame_check(1, "ed_even", 11'h5DA, 11, 20, 1'b0, 1'b0);

      // 8'hED, odd parity -> parity bit 1.
      set_in(2, 8'hED, 1'b1);
      @(negedge clk);
      frame_check(2, "ed_odd", 11'h7DA, 11, 20, 1'b0, 1'b0);

      // Back-to-back 8'h55 then 8'hA3 with start held high.
      set_in(0, 8'h55, 1'b1);
      @(negedge clk);
      set_in(0, 8'hA3, 1'b1);
      frame_check(0, "b2b_55", 11'h2AA, 10, 1, 1'b1, 1'b0);
      chk("b2b second start bit tx", 32'(if0.tx), 32'd0);
      chk("b2b second ready", 32'(if0.ready), 32'd0);
      frame_check(0, "b2b_a3", 11'h346, 10, 20, 1'b0, 1'b0);

      // start pulses at cycles 30 and 60 during an 8'h0F frame are ignored.
      set_in(0, 8'h0F, 1'b1);
      @(negedge clk);
      frame_check(0, "ign_0f", 11'h21E, 10, 20, 1'b0, 1'b1);

      // Asynchronous reset mid-DATA at cycle 45 (tx low there for 8'h00).
      set_in(0, 8'h00, 1'b1);
      @(negedge clk);
      set_start(0, 1'b0);
      repeat (45) @(negedge clk);
      chk("mid tx before reset", 32'(if0.tx), 32'd0);
      #2 reset = 1'b1;
      #1;
      chk("mid reset tx", 32'(if0.tx), 32'd1);
      chk("mid reset ready", 32'(if0.ready), 32'd1);
      chk("mid reset done", 32'(if0.done), 32'd0);
      #1 reset = 1'b0;
      @(negedge clk);
      bad      = 0;
      done_cnt = 0;
      for (int i = 0; i < 100; i++) begin
         if (if0.tx !== 1'b1 || if0.ready !== 1'b1) bad++;
         if (if0.done !== 1'b0) done_cnt++;
         @(negedge clk);
      end
      chk("after abort idle deviations", 32'(bad), 32'd0);
      chk("after abort done pulses", 32'(done_cnt), 32'd0);

      // Clean frame after the abort.
      set_in(0, 8'h01, 1'b1);
      @(negedge clk);
      frame_check(0, "post_rst_01", 11'h202, 10, 20, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
Standalone UART transmit framer: serialises one parallel word per start/ready handshake onto `tx` as start bit, data bits LSB-first, optional parity, then stop bit(s).
It is the transmit-side counterpart used by the `uart` receive path. A host-side producer feeds it, and its `tx` line drives the link or loops back into a receiver's `rx` for bench checking.
Bit timing is a fixed count of `clk` cycles per bit. There is no oversampling.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9)
- CLKS_PER_BIT, 10, clk cycles per bit period (>=2)
- PARITY, 0, 0 = none, 1 = even, 2 = odd
- STOP_BITS, 1, stop bit count (1 or 2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- datatx  in  DATA_WIDTH  word to send; sampled only on accept
- start  in  1  request to send; accepted when start=1 and ready=1 at a rising edge
- ready  out  1  high when idle and able to accept
- tx  out  1  serial line, idles high; registered output
- done  out  1  one-cycle pulse when the final stop bit period completes

Behaviour:
- Reset (async, immediate):
  - tx=1, ready=1, done=0
  - state=IDLE; bit and cycle counters cleared; shift register cleared
- States: IDLE -> START -> DATA -> PARITY (only if PARITY!=0) -> STOP -> IDLE.
- Accept: rising edge E0 with start=1 and ready=1.
  - At E0: latch datatx into the shift register; compute the parity bit from the latched word; ready<=0; tx<=0 (START).
  - The start bit is visible from E0 to E0+CLKS_PER_BIT.
- Bit period: every bit holds tx stable for exactly CLKS_PER_BIT cycles.
  - Cycle counter runs 0..CLKS_PER_BIT-1; the bit advances when the counter equals CLKS_PER_BIT-1.
- DATA: bit i is driven during period i+1; LSB first; shift right once per period.
- PARITY:
  - Even: tx = XOR of the data bits.
  - Odd: tx = inverted XOR of the data bits.
- STOP: tx=1 for STOP_BITS periods.
- Frame end:
  - N = 1 + DATA_WIDTH + (PARITY!=0) + STOP_BITS.
  - At edge E0 + N*CLKS_PER_BIT: ready<=1 and done<=1 (for one cycle only); tx stays 1.
- start while ready=0: ignored, not queued. datatx changes while busy: no effect.
- Back-to-back: if start=1 in the cycle where ready is high again, it is accepted on the next edge.
  - Minimum inter-frame idle is 1 cycle of tx=1 beyond the stop bit(s).
- Reset mid-frame: tx returns to 1 immediately; the frame is aborted; no done pulse.
- Counter widths: $clog2(CLKS_PER_BIT) for the cycle counter and $clog2(DATA_WIDTH+1) for the bit counter. No wrap beyond the terminal values.
- Elaboration guard: illegal parameter values (CLKS_PER_BIT<2, PARITY>2, STOP_BITS not 1/2) are a fatal elaboration error.

Decomposition:
- Shared package `uart_pkg`:
  - state enum (IDLE, START, DATA, PARITY, STOP)
  - parity encoding constants (PAR_NONE=0, PAR_EVEN=1, PAR_ODD=2)
  - default CLKS_PER_BIT=10, shared with the receiver
- Sub-module `uart_bit_timer`: cycle counter with sync clear, emitting a one-cycle `bit_end` pulse at count CLKS_PER_BIT-1. It is reused by the receive side.
- Everything else lives inline in the framer.

Test Plan:
- Reset held 53 ns, then released: tx=1, ready=1, done=0; they stay so with start=0 for 200 cycles.
- Send datatx=8'hED, start pulsed for 1 cycle (defaults):
  - tx per 10-cycle period is 0,1,0,1,1,0,1,1,1,1.
  - ready is low for exactly 100 cycles.
  - done pulses once at cycle 100.
- PARITY=1 with 8'hED: parity bit 0 and an 11-bit frame (110 cycles). PARITY=2: parity bit 1.
- Back-to-back: 8'h55 then 8'hA3, with start held high:
  - The second start bit begins 1 cycle after ready rises.
  - Loopback into `uart` rx gives datarx=8'h55 then 8'hA3 with rx_err=0.
- start pulsed at cycles 30 and 60 during an 8'h0F frame: ignored; exactly one frame and one done pulse.
- reset asserted asynchronously mid-DATA (cycle 45):
  - tx=1 and ready=1 before the next clk edge; no done pulse.
  - The next start with 8'h01 produces a clean full frame.
